// File: rtl/multicycle_control.sv
// Multi-cycle sequencer driving register-file, ALU and data-memory control lines.
// Optional retired-instruction counter enabled by defining CONTROL_RETIRE_CNT_EN.
module multicycle_control #(
  parameter int SIZE    = 32,
  parameter int COUNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [SIZE-1:0] instruction,
  output logic            instr_ready,
  output logic            done,
  output logic [4:0]      rf_addr_a,
  output logic [4:0]      rf_addr_b,
  output logic            rf_write_enable,
  output logic [4:0]      rf_write_addr,
  output logic            wb_sel,
  output logic            alu_op,
  output logic            dm_read,
  output logic            dm_write_enable,
  output logic [4:0]      dm_write_addr
`ifdef CONTROL_RETIRE_CNT_EN
  ,
  output logic [COUNT_W-1:0] retired_count
`endif
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [1:0] {OP_LW, OP_SW, OP_ADD, OP_SUB} opcode_t;

  state_t          state, state_next;
  logic [SIZE-1:0] ir;
  opcode_t         op;
  logic [4:0]      rd, rs1, rs2, maddr;

  assign op    = opcode_t'(ir[1:0]);
  assign rd    = ir[11:7];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign maddr = ir[31:27];

  // Bits of ir that carry no field for this instruction set.
  logic unused_ir;
  assign unused_ir = ^{ir[6:2], ir[14:12], ir[26:25]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && instr_valid)
        ir <= instruction;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (instr_valid) state_next = DECODE;
      DECODE:  state_next = (op == OP_ADD || op == OP_SUB) ? EXEC : MEM;
      EXEC:    state_next = WB;
      MEM:     state_next = (op == OP_LW) ? WB : IDLE;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready     = 1'b0;
    done            = 1'b0;
    rf_addr_a       = '0;
    rf_addr_b       = '0;
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    wb_sel          = 1'b0;
    alu_op          = 1'b0;
    dm_read         = 1'b0;
    dm_write_enable = 1'b0;
    dm_write_addr   = '0;
    unique case (state)
      IDLE: instr_ready = 1'b1;
      DECODE: begin
        rf_addr_a = rs1;
        rf_addr_b = rs2;
      end
      EXEC: begin
        rf_addr_a = rs1;
        rf_addr_b = rs2;
        alu_op    = ir[0];
      end
      MEM: begin
        dm_write_addr = maddr;
        if (op == OP_LW) begin
          dm_read = 1'b1;
        end else begin
          // Store data is read through port B, so the store retires here.
          dm_write_enable = 1'b1;
          rf_addr_b       = rs2;
          done            = 1'b1;
        end
      end
      WB: begin
        rf_write_enable = 1'b1;
        rf_write_addr   = rd;
        done            = 1'b1;
        wb_sel          = (op == OP_LW);
        alu_op          = (op == OP_LW) ? 1'b0 : ir[0];
      end
      default: ;
    endcase
  end

`ifdef CONTROL_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      retired_count <= '0;
    else if (done)
      retired_count <= retired_count + COUNT_W'(1);
  end
`else
  localparam int unused_count_w = COUNT_W;
`endif

endmodule
